// File: rtl/cpu_thread_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_thread_sched_pkg
// Brief    : Shared state encoding, defaults and helpers for the thread scheduler.
// Revision : 1.0
// ============================================================================
package cpu_thread_sched_pkg;

  typedef enum logic [2:0] {
    SCHED_IDLE   = 3'd0,
    SCHED_RUN    = 3'd1,
    SCHED_DRAIN  = 3'd2,
    SCHED_SAVE   = 3'd3,
    SCHED_SELECT = 3'd4,
    SCHED_LOAD   = 3'd5
  } sched_state_t;

  localparam int c_SCHED_N_THREADS = 4;
  localparam int c_SCHED_TIMESLICE = 16;

  // A single-thread build still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_thread_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : cpu_thread_rr_pick
// Brief    : Combinational circular priority search: lowest ready index at or
//            after i_start, wrapping modulo N_THREADS.
// Revision : 1.0
// ============================================================================
module cpu_thread_rr_pick #(
  parameter int N_THREADS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [N_THREADS-1:0] i_ready,
  input  logic [IDX_W-1:0]     i_start,
  output logic                 o_found,
  output logic [IDX_W-1:0]     o_index
);

  int w_pos;

  // Walk from the farthest candidate back to i_start so the nearest hit wins.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_pos   = 0;
    for (int k = N_THREADS - 1; k >= 0; k--) begin
      w_pos = int'(i_start) + k;
      if (w_pos >= N_THREADS) begin
        w_pos = w_pos - N_THREADS;
      end
      if (i_ready[w_pos[IDX_W-1:0]]) begin
        o_found = 1'b1;
        o_index = IDX_W'(w_pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_thread_sched.sv
`default_nettype none
// ============================================================================
// Module   : cpu_thread_sched
// Brief    : Round-robin thread context-switch controller driving flag save/load
//            strobes and instruction-issue gating. Optional macro:
//            CPU_SCHED_SKIP_CLEAN_SAVE_EN (skip SAVE when flags are clean).
// Revision : 1.0
// ============================================================================
module cpu_thread_sched
  import cpu_thread_sched_pkg::*;
#(
  parameter int N_THREADS     = c_SCHED_N_THREADS,
  parameter int N_THREADS_MSB = idx_width(N_THREADS) - 1,
  parameter int TIMESLICE     = c_SCHED_TIMESLICE
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [N_THREADS-1:0]     thread_ready,
  input  logic                     yield_req,
  input  logic                     instr_issued,
  input  logic                     pipeline_idle,
  input  logic                     flags_dirty,
  output logic [N_THREADS_MSB:0]   thread_num,
  output logic                     save_en,
  output logic                     load_en,
  output logic                     exec_en,
  output logic                     switch_done
);

  localparam int              IDX_W   = N_THREADS_MSB + 1;
  localparam int              CNT_W   = $clog2(TIMESLICE + 1);
  localparam logic [CNT_W-1:0] c_SLICE = CNT_W'(TIMESLICE);

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [IDX_W-1:0] r_thread_num;
  logic [IDX_W-1:0] w_thread_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] w_start;
  logic             w_found;
  logic [IDX_W-1:0] w_pick;
  logic             w_trigger;
  logic             r_save_en;
  logic             r_load_en;
  logic             r_exec_en;
  logic             r_switch_done;

  // The current thread is searched last, so a sole ready thread is re-picked.
  assign w_start = (r_thread_num == IDX_W'(N_THREADS - 1)) ? '0
                                                            : r_thread_num + 1'b1;

  cpu_thread_rr_pick #(
    .N_THREADS (N_THREADS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .i_ready (thread_ready),
    .i_start (w_start),
    .o_found (w_found),
    .o_index (w_pick)
  );

`ifndef CPU_SCHED_SKIP_CLEAN_SAVE_EN
  logic w_unused_flags_dirty;
  assign w_unused_flags_dirty = flags_dirty;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_thread_nxt = r_thread_num;
    w_cnt_nxt    = r_cnt;
    w_trigger    = 1'b0;
    case (r_state)
      SCHED_IDLE: begin
        if (|thread_ready) w_state_nxt = SCHED_SELECT;
      end
      SCHED_SELECT: begin
        if (w_found) begin
          w_thread_nxt = w_pick;
          w_state_nxt  = SCHED_LOAD;
        end else begin
          w_state_nxt  = SCHED_IDLE;
        end
      end
      SCHED_LOAD: begin
        w_cnt_nxt   = '0;
        w_state_nxt = SCHED_RUN;
      end
      SCHED_RUN: begin
        if (instr_issued && (r_cnt != c_SLICE)) w_cnt_nxt = r_cnt + 1'b1;
        // The issue in the trigger cycle itself counts toward expiry.
        w_trigger = yield_req || !thread_ready[r_thread_num] || (w_cnt_nxt == c_SLICE);
        if (w_trigger) w_state_nxt = SCHED_DRAIN;
      end
      SCHED_DRAIN: begin
        if (pipeline_idle) begin
`ifdef CPU_SCHED_SKIP_CLEAN_SAVE_EN
          w_state_nxt = flags_dirty ? SCHED_SAVE : SCHED_SELECT;
`else
          w_state_nxt = SCHED_SAVE;
`endif
        end
      end
      SCHED_SAVE: begin
        w_state_nxt = SCHED_SELECT;
      end
      default: begin
        w_state_nxt = SCHED_IDLE;
      end
    endcase
  end

  // Strobes are decoded from the next state so they align with the state register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state       <= SCHED_IDLE;
      r_thread_num  <= '0;
      r_cnt         <= '0;
      r_save_en     <= 1'b0;
      r_load_en     <= 1'b0;
      r_exec_en     <= 1'b0;
      r_switch_done <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_thread_num  <= w_thread_nxt;
      r_cnt         <= w_cnt_nxt;
      r_save_en     <= (w_state_nxt == SCHED_SAVE);
      r_load_en     <= (w_state_nxt == SCHED_LOAD);
      r_exec_en     <= (w_state_nxt == SCHED_RUN);
      r_switch_done <= (w_state_nxt == SCHED_RUN) && (r_state == SCHED_LOAD);
    end
  end

  assign thread_num  = r_thread_num;
  assign save_en     = r_save_en;
  assign load_en     = r_load_en;
  assign exec_en     = r_exec_en;
  assign switch_done = r_switch_done;

endmodule
`default_nettype wire

// File: tb/tb_cpu_thread_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_thread_sched
// Brief    : Directed table-driven bench for cpu_thread_sched (N_THREADS=4,
//            TIMESLICE=16); honours CPU_SCHED_SKIP_CLEAN_SAVE_EN if defined.
// Revision : 1.0
// ============================================================================
module tb_cpu_thread_sched;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] thread_ready = '0;
  logic       yield_req = 1'b0;
  logic       instr_issued = 1'b0;
  logic       pipeline_idle = 1'b0;
  logic       flags_dirty = 1'b0;
  logic [1:0] thread_num;
  logic       save_en;
  logic       load_en;
  logic       exec_en;
  logic       switch_done;

  int n_vec  = 0;
  int n_fail = 0;

  cpu_thread_sched dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .thread_ready  (thread_ready),
    .yield_req     (yield_req),
    .instr_issued  (instr_issued),
    .pipeline_idle (pipeline_idle),
    .flags_dirty   (flags_dirty),
    .thread_num    (thread_num),
    .save_en       (save_en),
    .load_en       (load_en),
    .exec_en       (exec_en),
    .switch_done   (switch_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst_n;
    logic [3:0] rdy;
    logic       yld;
    logic       iss;
    logic       idl;
    logic       drt;
    logic [5:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [5:0] pk(input logic [1:0] tn, input logic s, input logic l,
                                    input logic e, input logic d);
    return {tn, s, l, e, d};
  endfunction

  function automatic logic [5:0] obs();
    return {thread_num, save_en, load_en, exec_en, switch_done};
  endfunction

  function automatic vec_t mk(input logic rst_n, input logic [3:0] rdy, input logic yld,
                              input logic iss, input logic idl, input logic [5:0] exp);
    vec_t v;
    v.rst_n = rst_n; v.rdy = rdy; v.yld = yld; v.iss = iss; v.idl = idl; v.drt = 1'b0;
    v.exp = exp;
    return v;
  endfunction

  task automatic step(input logic rst_n, input logic [3:0] rdy, input logic yld,
                      input logic iss, input logic idl, input logic drt);
    @(negedge CLK);
    RESET_N = rst_n; thread_ready = rdy; yield_req = yld;
    instr_issued = iss; pipeline_idle = idl; flags_dirty = drt;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Counts consecutive exec_en cycles, starting from a RUN cycle already observed.
  task automatic run_len(input logic [3:0] rdy, output int len);
    len = 1;
    for (int i = 0; i < 40 && exec_en; i++) begin
      step(1'b1, rdy, 1'b0, 1'b1, 1'b1, 1'b0);
      if (exec_en) len++;
    end
  endtask

  task automatic measure_switch(input logic drt);
    int   zeros;
    logic saw;
    int   skip;
    skip = 0;
`ifdef CPU_SCHED_SKIP_CLEAN_SAVE_EN
    skip = 1;
`endif
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, drt);
    step(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, drt);
    step(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, drt);
    step(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, drt);
    chk("sw_run_entry", obs(), pk(2'd1, 1'b0, 1'b0, 1'b1, 1'b1));
    step(1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, drt);
    zeros = 0;
    saw   = 1'b0;
    for (int i = 0; i < 20 && !exec_en; i++) begin
      zeros++;
      saw = saw | save_en;
      step(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, drt);
    end
    chk(drt ? "sw_dirty_gap" : "sw_clean_gap", zeros, (skip != 0 && !drt) ? 3 : 4);
    chk(drt ? "sw_dirty_save" : "sw_clean_save", saw, (skip != 0 && !drt) ? 0 : 1);
    chk("sw_done", obs(), pk(2'd1, 1'b0, 1'b0, 1'b1, 1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    // Basic select, yield with wrap, double trigger with stalled drain.
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, pk(0, 0, 0, 0, 0)));
    vq.push_back(mk(1, 4'b0100, 0, 0, 0, pk(0, 0, 0, 0, 0)));
    vq.push_back(mk(1, 4'b0100, 0, 0, 0, pk(2, 0, 1, 0, 0)));
    vq.push_back(mk(1, 4'b0100, 0, 0, 0, pk(2, 0, 0, 1, 1)));
    vq.push_back(mk(1, 4'b0100, 0, 0, 0, pk(2, 0, 0, 1, 0)));
    vq.push_back(mk(1, 4'b0101, 1, 0, 1, pk(2, 0, 0, 0, 0)));
    vq.push_back(mk(1, 4'b0101, 0, 0, 1, pk(2, 1, 0, 0, 0)));
    vq.push_back(mk(1, 4'b0101, 0, 0, 1, pk(2, 0, 0, 0, 0)));
    vq.push_back(mk(1, 4'b0101, 0, 0, 1, pk(0, 0, 1, 0, 0)));
    vq.push_back(mk(1, 4'b0101, 0, 0, 1, pk(0, 0, 0, 1, 1)));
    vq.push_back(mk(1, 4'b0100, 1, 0, 0, pk(0, 0, 0, 0, 0)));
    vq.push_back(mk(1, 4'b0100, 0, 0, 0, pk(0, 0, 0, 0, 0)));
    vq.push_back(mk(1, 4'b0100, 0, 0, 1, pk(0, 1, 0, 0, 0)));
    vq.push_back(mk(1, 4'b0000, 0, 0, 1, pk(0, 0, 0, 0, 0)));
    vq.push_back(mk(1, 4'b0000, 0, 0, 1, pk(0, 0, 0, 0, 0)));
    vq.push_back(mk(1, 4'b0000, 0, 0, 1, pk(0, 0, 0, 0, 0)));
    // Thread 3, yield with nothing ready: park in IDLE keeping thread_num.
    vq.push_back(mk(1, 4'b1000, 0, 0, 1, pk(0, 0, 0, 0, 0)));
    vq.push_back(mk(1, 4'b1000, 0, 0, 1, pk(3, 0, 1, 0, 0)));
    vq.push_back(mk(1, 4'b1000, 0, 0, 1, pk(3, 0, 0, 1, 1)));
    vq.push_back(mk(1, 4'b0000, 1, 0, 1, pk(3, 0, 0, 0, 0)));
    vq.push_back(mk(1, 4'b0000, 0, 0, 1, pk(3, 1, 0, 0, 0)));
    vq.push_back(mk(1, 4'b0000, 0, 0, 1, pk(3, 0, 0, 0, 0)));
    vq.push_back(mk(1, 4'b0000, 0, 0, 1, pk(3, 0, 0, 0, 0)));
    vq.push_back(mk(1, 4'b0000, 0, 0, 1, pk(3, 0, 0, 0, 0)));
    // Sole ready thread re-selected, then reset lands during SAVE.
    vq.push_back(mk(1, 4'b1000, 0, 0, 1, pk(3, 0, 0, 0, 0)));
    vq.push_back(mk(1, 4'b1000, 0, 0, 1, pk(3, 0, 1, 0, 0)));
    vq.push_back(mk(1, 4'b1000, 0, 0, 1, pk(3, 0, 0, 1, 1)));
    vq.push_back(mk(1, 4'b1000, 1, 0, 1, pk(3, 0, 0, 0, 0)));
    vq.push_back(mk(1, 4'b1000, 0, 0, 1, pk(3, 1, 0, 0, 0)));
    vq.push_back(mk(0, 4'b1000, 0, 0, 1, pk(0, 0, 0, 0, 0)));
    vq.push_back(mk(1, 4'b0000, 0, 0, 1, pk(0, 0, 0, 0, 0)));

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst_n, vq[i].rdy, vq[i].yld, vq[i].iss, vq[i].idl, vq[i].drt);
      chk($sformatf("vec%0d", i), obs(), vq[i].exp);
    end

    // Timeslice expiry with a sole ready thread and issue held high.
    step(1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ts_load", obs(), pk(2'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    step(1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ts_run", obs(), pk(2'd1, 1'b0, 1'b0, 1'b1, 1'b1));
    run_len(4'b0010, len);
    chk("ts_slice_len", len, 16);
    step(1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ts_save", obs(), pk(2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ts_reload", obs(), pk(2'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    step(1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ts_rerun", obs(), pk(2'd1, 1'b0, 1'b0, 1'b1, 1'b1));
    run_len(4'b0010, len);
    chk("ts_slice_len2", len, 16);

    // Drain held off by a busy pipeline.
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("dr_run", obs(), pk(2'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    step(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dr_enter", obs(), pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("dr_hold%0d", i), obs(), pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("dr_save", obs(), pk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("dr_select", obs(), pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("dr_load", obs(), pk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0));

    // Clean vs dirty flags on a switch.
    measure_switch(1'b0);
    measure_switch(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_thread_sched.md
Name: cpu_thread_sched

Overview:
- Thread context-switch controller; the initiator side of the per-thread flag context interface.
- Drives thread_num, save_en and load_en into the CPU flag block, and gates instruction issue with exec_en.
- Round-robin selection over ready threads; switches on yield, timeslice expiry, or loss of readiness.
- Guarantees flags are saved only after the pipeline drains, and are reloaded before issue resumes.

Parameters:
- N_THREADS, `N_THREADS (default 4): number of hardware threads.
- N_THREADS_MSB, `MSB(N_THREADS-1): MSB of the thread index.
- TIMESLICE, 16: instructions issued per thread before a forced switch; must be ≥1.

Ports:
- CLK  in  1  clock.
- RESET_N  in  1  synchronous, active-low reset.
- thread_ready  in  N_THREADS  bit k=1: thread k has work.
- yield_req  in  1  current thread requests a switch; sampled only in RUN.
- instr_issued  in  1  one instruction was issued this cycle; counted only in RUN.
- pipeline_idle  in  1  no instructions in flight; flags are final.
- flags_dirty  in  1  flags were modified since the last load; used only by the optional feature.
- thread_num  out  N_THREADS_MSB+1  current context index (registered).
- save_en  out  1  one-cycle strobe: store flags of thread_num.
- load_en  out  1  one-cycle strobe: load flags of thread_num.
- exec_en  out  1  instruction issue permitted.
- switch_done  out  1  one-cycle pulse on the first RUN cycle of a new context.

Behaviour:
- All outputs are registered. Reset (synchronous, RESET_N=0 at an edge), including mid-switch:
  - state=IDLE, thread_num=0, save_en=load_en=exec_en=switch_done=0, slice count=0.
  - Any strobe in progress is dropped; no save occurs.
- States: IDLE, RUN, DRAIN, SAVE, SELECT, LOAD.
- IDLE: no context is held.
  - Go to SELECT when |thread_ready.
  - Transition decisions use inputs sampled at the clock edge.
- SELECT (1 cycle): pick the lowest index i ≥ (thread_num+1) mod N_THREADS, searching circularly, with thread_ready[i]=1.
  - The current thread is eligible last, so a sole ready thread is re-selected.
  - Selected index is registered into thread_num; go to LOAD.
  - None ready: go to IDLE with thread_num unchanged.
- LOAD (1 cycle): load_en=1 with thread_num stable. Next state RUN, slice count=0.
- RUN: exec_en=1; switch_done=1 on the first RUN cycle only.
  - instr_issued increments the slice count (saturating, width $clog2(TIMESLICE+1)).
  - Switch trigger is any of:
    - yield_req,
    - thread_ready[thread_num]=0,
    - count reaching TIMESLICE (including via instr_issued in the same cycle).
  - Simultaneous triggers produce exactly one switch.
  - On trigger: exec_en deasserts in the next cycle, go to DRAIN. The issue in the trigger cycle itself is counted and allowed.
- DRAIN: exec_en=0; wait for pipeline_idle=1, then go to SAVE. If pipeline_idle is already 1 on entry, DRAIN lasts exactly 1 cycle.
- SAVE (1 cycle): save_en=1, thread_num unchanged; go to SELECT.
- Invariants:
  - save_en and load_en are never high together.
  - thread_num changes only on the SELECT→LOAD edge.
  - exec_en=0 in every state except RUN.
- Minimum switch latency, trigger to next RUN: DRAIN 1 + SAVE 1 + SELECT 1 + LOAD 1 = 4 cycles with exec_en=0.
- thread_num wrap: N_THREADS-1 → 0 via the circular search. Non-power-of-2 N_THREADS is supported; the search mod is explicit.

Optional Feature:
- Macro: CPU_SCHED_SKIP_CLEAN_SAVE_EN.
- Defined: on leaving DRAIN with flags_dirty=0, skip SAVE and go directly to SELECT. The saved context is already current, so minimum switch latency drops to 3 cycles.
- Undefined: flags_dirty is ignored and SAVE always runs.

Decomposition:
- Shared md5.vh additions:
  - state encodings `SCHED_IDLE..`SCHED_LOAD (3 bits),
  - `SCHED_TIMESLICE default.
  - Reuse the existing `N_THREADS and `MSB macros.
- One sub-module, cpu_thread_rr_pick: combinational circular priority search.
  - Inputs: ready mask, start index.
  - Outputs: found, index.
  - Unit-testable separately.

Test Plan:
- Reset, then thread_ready=4'b0100 → SELECT, then LOAD with thread_num=2, load_en for 1 cycle, then RUN with exec_en=1 and switch_done pulse.
- Thread 2 running, thread_ready=4'b0101, yield_req, pipeline_idle=1 → DRAIN, SAVE (save_en, thread_num=2), SELECT, LOAD thread_num=0 (wrap from 2 past 3); exactly 4 cycles exec_en=0.
- TIMESLICE=16, instr_issued held 1 → 16th issue triggers switch; with sole ready thread 1 → save 1, reload 1, count reset to 0.
- pipeline_idle held 0 for 5 cycles in DRAIN → save_en delayed until pipeline_idle=1; no load_en before save_en.
- Yield while all thread_ready=0 after SAVE → IDLE, exec_en=0, thread_num kept; RESET_N=0 asserted during SAVE → save_en=0 next cycle, state IDLE, thread_num=0.
- CPU_SCHED_SKIP_CLEAN_SAVE_EN defined, flags_dirty=0 on yield → no save_en pulse, 3-cycle switch; flags_dirty=1 → SAVE present.
